// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 width codes,
// FSM state encoding and the access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // A legal access needs a width code valid for its direction and natural alignment.
  function automatic logic access_ok(input logic we, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic f3_ok;
    logic align_ok;
    case (f3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = ~we;
      default:          f3_ok = 1'b0;
    endcase
    case (f3[1:0])
      2'b01:   align_ok = ~off[0];
      2'b10:   align_ok = (off == 2'b00);
      default: align_ok = 1'b1;
    endcase
    return f3_ok & align_ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/acknowledge data bus between the load/store unit and memory.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata, bus_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: replicates store data across lanes with byte enables,
// and extracts/extends the addressed lane of a load word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  function automatic logic [31:0] ext8(input logic signed [7:0] b, input logic sx);
    return sx ? {{24{b[7]}}, b} : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic signed [15:0] h, input logic sx);
    return sx ? {{16{h[15]}}, h} : {16'd0, h};
  endfunction

  logic [31:0]        ld_shift;
  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;

  always_comb begin
    st_wdata = st_data;
    st_be    = 4'b1111;
    case (st_funct3[1:0])
      2'b00: begin
        st_wdata = {4{st_data[7:0]}};
        st_be    = 4'b0001 << st_off;
      end
      2'b01: begin
        st_wdata = {2{st_data[15:0]}};
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Shift the addressed lane down to bit 0 so byte/half selection is uniform.
  assign ld_shift = ld_word >> {ld_off, 3'b000};
  assign ld_byte  = ld_shift[7:0];
  assign ld_half  = ld_shift[15:0];

  always_comb begin
    ld_data = ld_word;
    case (ld_funct3)
      F3_B:    ld_data = ext8(ld_byte, 1'b1);
      F3_BU:   ld_data = ext8(ld_byte, 1'b0);
      F3_H:    ld_data = ext16(ld_half, 1'b1);
      F3_HU:   ld_data = ext16(ld_half, 1'b0);
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: turns one load/store per instruction into a bus
// transaction, stalling the core until it completes, errors or times out.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  load_store_unit_if.master bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t    state, state_nx;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          legal;
  logic          timeout;
  logic [31:0]   st_wdata;
  logic [3:0]    st_be;
  logic [31:0]   ld_data;

  assign legal   = access_ok(we, funct3, addr[1:0]);
  // Expires on the TIMEOUT_CYCLES-th REQ cycle without an ack.
  assign timeout = (({1'b0, cnt} + (CW + 1)'(1)) == (CW + 1)'(TIMEOUT_CYCLES));

  lsu_lane_align u_align (
    .st_funct3 (funct3),
    .st_off    (addr[1:0]),
    .st_data   (wdata),
    .st_wdata  (st_wdata),
    .st_be     (st_be),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .ld_word   (bus.bus_rdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        stall = start;
        if (start) state_nx = legal ? REQ : DONE;
      end
      REQ: begin
        stall = 1'b1;
        if (bus.bus_ack || timeout) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bus launch in IDLE, completion or timeout in REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      err           <= 1'b0;
      rdata         <= 32'd0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'd0;
      bus.bus_wdata <= 32'd0;
      bus.bus_be    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              cnt           <= '0;
              we_q          <= we;
              f3_q          <= funct3;
              off_q         <= addr[1:0];
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= we;
              bus.bus_addr  <= {addr[31:2], 2'b00};
              bus.bus_wdata <= st_wdata;
              bus.bus_be    <= we ? st_be : 4'b1111;
            end else begin
              err <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            err         <= bus.bus_err;
            if (!we_q && !bus.bus_err) rdata <= ld_data;
          end else if (timeout) begin
            bus.bus_req <= 1'b0;
            err         <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised and directed bench for load_store_unit against a transaction-level model.
module tb_load_store_unit;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall, done, err;
  logic [31:0] rdata;

  int          nvec = 0;
  int          nbad = 0;
  logic [31:0] rd_model = 32'd0;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .we     (we),
    .funct3 (funct3),
    .addr   (addr),
    .wdata  (wdata),
    .stall  (stall),
    .done   (done),
    .rdata  (rdata),
    .err    (err),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic legal_m(input logic w, input logic [2:0] f3, input logic [1:0] off);
    int size;
    if (w && f3 > 3'd2) return 1'b0;
    if (!w && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    size = 1 << f3[1:0];
    return (int'(off) % size) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] off);
    int n;
    n = 1 << f3[1:0];
    return 4'(((1 << n) - 1) << int'(off));
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return 32'(d[7:0]) * 32'h0101_0101;
      2'd1:    return 32'(d[15:0]) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * int'(off));
    case (f3)
      3'd0:    return (v & 32'hFF) | (v[7] ? 32'hFFFF_FF00 : 32'd0);
      3'd1:    return (v & 32'hFFFF) | (v[15] ? 32'hFFFF_0000 : 32'd0);
      3'd4:    return v & 32'hFF;
      3'd5:    return v & 32'hFFFF;
      default: return d;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start         = 1'b0;
      bus.bus_ack   = 1'($urandom);
      bus.bus_rdata = $urandom;
      bus.bus_err   = 1'($urandom);
    end
  endtask

  // One instruction: ack on the (dly+1)-th REQ cycle; dly >= TO never acks.
  task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] brd,
                        input int dly, input logic berr);
    int   cycles, stalls, reqn, e_cyc, e_st, e_req;
    logic seen, legal, e_err;
    legal = legal_m(w, f3, a[1:0]);
    @(negedge clk);
    start = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    cycles = 0; stalls = 0; reqn = 0; seen = 1'b0;
    while (!seen && cycles < TO + 10) begin
      if (cycles > 0) @(negedge clk);
      cycles++;
      if (bus.bus_req) begin
        reqn++;
        bus.bus_ack   = (reqn == dly + 1);
        bus.bus_rdata = bus.bus_ack ? brd : $urandom;
        bus.bus_err   = bus.bus_ack ? berr : 1'($urandom);
        chk("bus_addr", bus.bus_addr, a & 32'hFFFF_FFFC);
        chk("bus_we", 32'(bus.bus_we), 32'(w));
        chk("bus_be", 32'(bus.bus_be), w ? 32'(exp_be(f3, a[1:0])) : 32'hF);
        if (w) chk("bus_wdata", bus.bus_wdata, exp_wd(f3, wd));
      end else begin
        bus.bus_ack   = 1'($urandom);
        bus.bus_rdata = $urandom;
        bus.bus_err   = 1'($urandom);
      end
      #1;
      if (cycles == 1) chk("done_first", 32'(done), 32'd0);
      if (stall) stalls++;
      if (done) seen = 1'b1;
    end
    if (!legal) begin
      e_err = 1'b1; e_cyc = 2; e_st = 1; e_req = 0;
    end else if (dly < TO) begin
      e_err = berr; e_cyc = dly + 3; e_st = dly + 2; e_req = dly + 1;
      if (!w && !berr) rd_model = exp_ld(f3, a[1:0], brd);
    end else begin
      e_err = 1'b1; e_cyc = TO + 2; e_st = TO + 1; e_req = TO;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(cycles), 32'(e_cyc));
    chk("stall_cycles", 32'(stalls), 32'(e_st));
    chk("req_cycles", 32'(reqn), 32'(e_req));
    chk("err", 32'(err), 32'(e_err));
    chk("rdata", rdata, rd_model);
  endtask

  initial begin
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'd0; bus.bus_err = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_req", 32'(bus.bus_req), 32'd0);
    chk("rst_we", 32'(bus.bus_we), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", bus.bus_addr, 32'd0);
    chk("rst_wdata", bus.bus_wdata, 32'd0);
    chk("rst_be", 32'(bus.bus_be), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    access(1'b0, 3'd0, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0, 1'b0);
    chk("lb_value", rdata, 32'hFFFF_FF80);
    access(1'b0, 3'd5, 32'h0000_0202, 32'd0, 32'hBEEF_0000, 5, 1'b0);
    chk("lhu_value", rdata, 32'h0000_BEEF);
    access(1'b1, 3'd0, 32'h0000_0301, 32'h0000_00A5, 32'd0, 0, 1'b0);
    access(1'b0, 3'd2, 32'h0000_0402, 32'd0, 32'h1111_1111, 0, 1'b0);
    access(1'b1, 3'd4, 32'h0000_0400, 32'h1234_5678, 32'd0, 0, 1'b0);
    idle(2);
    access(1'b0, 3'd2, 32'h0000_0600, 32'd0, 32'h2222_2222, TO, 1'b0);
    access(1'b0, 3'd2, 32'h0000_0604, 32'd0, 32'h3333_3333, TO - 1, 1'b0);
    access(1'b0, 3'd1, 32'h0000_0606, 32'd0, 32'h4444_5555, 2, 1'b1);
    access(1'b1, 3'd1, 32'h0000_0702, 32'h0000_C0DE, 32'd0, 1, 1'b0);

    // Reset in the middle of a bus cycle
    @(negedge clk);
    start = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h0000_0500;
    bus.bus_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      bus.bus_ack = 1'b0;
    end
    chk("pre_rst_req", 32'(bus.bus_req), 32'd1);
    rst_n = 1'b0; start = 1'b0;
    #1;
    rd_model = 32'd0;
    chk("mid_rst_req", 32'(bus.bus_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 3'd2, 32'h0000_0500, 32'd0, 32'hCAFE_F00D, 1, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1 && f3 == 3'd0) f3 = 3'd4;
      access(1'($urandom), f3, $urandom, $urandom, $urandom,
             $urandom_range(0, TO), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
